// File: rtl/direct_channel_arbiter_fifo.sv
// direct_channel_arbiter_fifo
//   Input stage for a PU's direct (blocking) channels. Each channel has its
//   own FIFO_DEPTH-entry FIFO. A round-robin arbiter feeds one registered
//   valid/ready output slot.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   clear                 synchronous flush (FIFOs, output slot, rr, stats)
//   direct_in_channels_*  per-channel packed data, valid, combinational accept
//   out_data/out_channel  message presented to the PU and its source channel
//   out_valid/out_ready   output handshake
//   is_processing         any FIFO non-empty or out_valid
//   fifo_full             per-channel full flag (registered)
//
// Optional: define DIRECT_ARBITER_STATS_EN to add stat_accepted,
//   stat_max_occupancy and stat_stall_cycles.

module direct_channel_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic                       full
`ifdef DIRECT_ARBITER_STATS_EN
  ,output logic [$clog2(DEPTH):0]    occupancy
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // The pointers differ only in the MSB when the FIFO is full.
  localparam logic [PW-1:0] MSB_ONLY = {1'b1, {(PW-1){1'b0}}};

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          full_q, full_d;

  assign wptr_d = wptr_q + PW'(push);
  assign rptr_d = rptr_q + PW'(pop);
  assign full_d = (wptr_d ^ rptr_d) == MSB_ONLY;

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full_q <= full_d;
    end
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = full_q;
`ifdef DIRECT_ARBITER_STATS_EN
  assign occupancy = wptr_q - rptr_q;
`endif
endmodule

module direct_channel_arbiter_fifo #(
  parameter int ADDRESS_WIDTH        = 9,
  parameter int CHANNEL_COUNT        = 6,
  parameter int FIFO_DEPTH           = 4,
  parameter int DIRECT_MESSAGE_WIDTH = ADDRESS_WIDTH + 2,
  localparam int CW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clear,
  input  logic [DIRECT_MESSAGE_WIDTH*CHANNEL_COUNT-1:0] direct_in_channels_data,
  input  logic [CHANNEL_COUNT-1:0]                      direct_in_channels_valid,
  output logic [CHANNEL_COUNT-1:0]                      direct_in_channels_is_taken,
  output logic [DIRECT_MESSAGE_WIDTH-1:0]               out_data,
  output logic [CW-1:0]                                 out_channel,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          is_processing,
  output logic [CHANNEL_COUNT-1:0]                      fifo_full
`ifdef DIRECT_ARBITER_STATS_EN
  ,output logic [15:0]                                  stat_accepted
  ,output logic [$clog2(FIFO_DEPTH):0]                  stat_max_occupancy
  ,output logic [15:0]                                  stat_stall_cycles
`endif
);
  localparam int W  = DIRECT_MESSAGE_WIDTH;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  logic                          flush;
  logic [CHANNEL_COUNT-1:0]      empty, full, pop;
  logic [CHANNEL_COUNT-1:0][W-1:0] head;
  logic [CW-1:0]                 rr_q, rr_d, grant;
  logic                          any_ne, load;
  logic [W-1:0]                  out_data_q;
  logic [CW-1:0]                 out_channel_q;
  logic                          out_valid_q;

  assign flush = reset | clear;
  assign direct_in_channels_is_taken = direct_in_channels_valid & ~full
                                     & {CHANNEL_COUNT{~flush}};

`ifdef DIRECT_ARBITER_STATS_EN
  logic [CHANNEL_COUNT-1:0][OW-1:0] occ;
`endif

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
    direct_channel_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .flush    (flush),
      .push     (direct_in_channels_is_taken[c]),
      .wdata    (direct_in_channels_data[c*W +: W]),
      .pop      (pop[c]),
      .rdata    (head[c]),
      .empty    (empty[c]),
      .full     (full[c])
`ifdef DIRECT_ARBITER_STATS_EN
      ,.occupancy(occ[c])
`endif
    );
  end

  // Round-robin: first non-empty channel at or after rr_q, wrapping.
  always_comb begin
    int idx;
    grant  = '0;
    any_ne = 1'b0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= CHANNEL_COUNT) idx = idx - CHANNEL_COUNT;
      if (!any_ne && !empty[idx]) begin
        any_ne = 1'b1;
        grant  = CW'(idx);
      end
    end
  end

  // Slot reloads when empty or when the PU takes the current message.
  assign load = any_ne & (~out_valid_q | out_ready);
  assign rr_d = (grant == CW'(CHANNEL_COUNT-1)) ? '0 : grant + CW'(1);

  always_comb begin
    pop = '0;
    if (load) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      rr_q          <= '0;
    end else if (load) begin
      out_data_q    <= head[grant];
      out_channel_q <= grant;
      out_valid_q   <= 1'b1;
      rr_q          <= rr_d;
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_data      = out_data_q;
  assign out_channel   = out_channel_q;
  assign out_valid     = out_valid_q;
  assign fifo_full     = full;
  assign is_processing = (|(~empty)) | out_valid_q;

`ifdef DIRECT_ARBITER_STATS_EN
  logic [15:0]   acc_q, stall_q;
  logic [OW-1:0] max_q, max_d;
  logic [4:0]    n_taken;
  logic [16:0]   acc_sum;

  always_comb begin
    n_taken = '0;
    max_d   = max_q;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      n_taken = n_taken + 5'(direct_in_channels_is_taken[c]);
      if (occ[c] > max_d) max_d = occ[c];
    end
  end
  assign acc_sum = {1'b0, acc_q} + 17'(n_taken);

  always_ff @(posedge clk) begin
    if (flush) begin
      acc_q   <= '0;
      stall_q <= '0;
      max_q   <= '0;
    end else begin
      acc_q <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
      max_q <= max_d;
      if (out_valid_q && !out_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign stat_accepted      = acc_q;
  assign stat_max_occupancy = max_q;
  assign stat_stall_cycles  = stall_q;
`endif
endmodule

// File: tb/tb_direct_channel_arbiter_fifo.sv
module tb_direct_channel_arbiter_fifo;
  localparam int AWD = 9;
  localparam int CC  = 6;
  localparam int FD  = 4;
  localparam int W   = AWD + 2;

  logic              clk = 1'b0;
  logic              reset, clear, out_ready;
  logic [W*CC-1:0]   in_data;
  logic [CC-1:0]     in_valid, is_taken, fifo_full;
  logic [W-1:0]      out_data;
  logic [2:0]        out_channel;
  logic              out_valid, is_processing;
`ifdef DIRECT_ARBITER_STATS_EN
  logic [15:0]       stat_accepted, stat_stall_cycles;
  logic [2:0]        stat_max_occupancy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  direct_channel_arbiter_fifo #(
    .ADDRESS_WIDTH(AWD), .CHANNEL_COUNT(CC), .FIFO_DEPTH(FD)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .clear                      (clear),
    .direct_in_channels_data    (in_data),
    .direct_in_channels_valid   (in_valid),
    .direct_in_channels_is_taken(is_taken),
    .out_data                   (out_data),
    .out_channel                (out_channel),
    .out_valid                  (out_valid),
    .out_ready                  (out_ready),
    .is_processing              (is_processing),
    .fifo_full                  (fifo_full)
`ifdef DIRECT_ARBITER_STATS_EN
    ,.stat_accepted             (stat_accepted)
    ,.stat_max_occupancy        (stat_max_occupancy)
    ,.stat_stall_cycles         (stat_stall_cycles)
`endif
  );

  // Distinct message per (channel, sequence number).
  function automatic logic [W-1:0] msg(input int ch, input int k);
    logic [AWD-1:0] r;
    logic [31:0] kk, cc;
    r  = AWD'(ch * 16 + k);
    kk = k;
    cc = ch;
    return {r, kk[0], cc[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = '1; in_data = '0; out_ready = 1'b0;
    #1;
    checks++;
    if (is_taken !== 6'b0) begin errors++; $display("FAIL reset_taken got %b exp 000000", is_taken); end
    tick(); tick();
    reset = 1'b0; in_valid = '0;
    #1;
    checks++;
    if ({out_valid, out_data, out_channel, fifo_full, is_processing} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h ch=%0d full=%b proc=%b exp all zero",
               out_valid, out_data, out_channel, fifo_full, is_processing);
    end
`ifdef DIRECT_ARBITER_STATS_EN
    checks++;
    if ({stat_accepted, stat_max_occupancy, stat_stall_cycles} !== '0) begin
      errors++; $display("FAIL reset_stats got %h %h %h exp 0", stat_accepted, stat_max_occupancy, stat_stall_cycles);
    end
`endif
  endtask

  task automatic test_single();
    logic [W-1:0] m;
    do_reset();
    m = {9'h05, 1'b1, 1'b0};
    out_ready = 1'b1;
    in_valid = 6'b000100;
    in_data[2*W +: W] = m;
    #1;
    checks++;
    if (is_taken !== 6'b000100) begin errors++; $display("FAIL single_taken got %b exp 000100", is_taken); end
    tick();
    in_valid = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || is_processing !== 1'b1) begin
      errors++; $display("FAIL single_edge1 got v=%b proc=%b exp v=0 proc=1", out_valid, is_processing);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== m || out_channel !== 3'd2) begin
      errors++; $display("FAIL single_out got v=%b d=%h ch=%0d exp v=1 d=%h ch=2", out_valid, out_data, out_channel, m);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || is_processing !== 1'b0) begin
      errors++; $display("FAIL single_done got v=%b proc=%b exp 0 0", out_valid, is_processing);
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    out_ready = 1'b1;
    in_valid = '1;
    for (int c = 0; c < CC; c++) in_data[c*W +: W] = msg(c, 0);
    #1;
    checks++;
    if (is_taken !== 6'b111111) begin errors++; $display("FAIL all_taken got %b exp 111111", is_taken); end
    tick();
    in_valid = '0;
    for (int i = 0; i < CC; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_channel !== 3'(i) || out_data !== msg(i, 0)) begin
        errors++; $display("FAIL all_order[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                           i, out_valid, out_channel, out_data, i, msg(i, 0));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL all_end got v=%b exp 0", out_valid); end
  endtask

  task automatic test_full_backpressure();
    int n, takes, stall;
    do_reset();
    n = 0; takes = 0; stall = 0;
    for (int t = 0; t < 8; t++) begin
      in_valid = 6'b000010;
      in_data[1*W +: W] = msg(1, n);
      #1;
      if (out_valid && !out_ready) stall++;
      if (is_taken[1]) begin takes++; n++; end
      tick();
    end
    checks++;
    if (takes !== 5) begin errors++; $display("FAIL full_takes got %0d exp 5", takes); end
    in_data[1*W +: W] = msg(1, n);
    #1;
    checks++;
    if (fifo_full !== 6'b000010 || is_taken[1] !== 1'b0) begin
      errors++; $display("FAIL full_flag got full=%b taken=%b exp full=000010 taken=0", fifo_full, is_taken[1]);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== msg(1, 0)) begin
      errors++; $display("FAIL full_hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, msg(1, 0));
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== msg(1, i)) begin
        errors++; $display("FAIL full_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, msg(1, i));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || is_processing !== 1'b0 || fifo_full !== 6'b0) begin
      errors++; $display("FAIL full_empty got v=%b proc=%b full=%b exp 0 0 000000", out_valid, is_processing, fifo_full);
    end
`ifdef DIRECT_ARBITER_STATS_EN
    checks++;
    if (stat_accepted !== 16'd5 || stat_max_occupancy !== 3'd4 || stat_stall_cycles !== 16'(stall)
        || stall !== 6) begin
      errors++; $display("FAIL full_stats got acc=%0d max=%0d stall=%0d exp acc=5 max=4 stall=%0d (6)",
                         stat_accepted, stat_max_occupancy, stat_stall_cycles, stall);
    end
`endif
  endtask

  task automatic test_round_robin();
    int n;
    int rec_ch [16];
    logic [W-1:0] rec_d [16];
    do_reset();
    out_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 10; t++) begin
      if (t < 3) begin
        in_valid = 6'b001001;
        in_data[0*W +: W] = msg(0, t);
        in_data[3*W +: W] = msg(3, t);
      end else begin
        in_valid = '0;
      end
      #1;
      if (out_valid && n < 16) begin
        rec_ch[n] = int'(out_channel);
        rec_d[n]  = out_data;
        n++;
      end
      tick();
    end
    checks++;
    if (n !== 6) begin errors++; $display("FAIL rr_count got %0d exp 6", n); end
    for (int i = 0; i < 6 && i < n; i++) begin
      checks++;
      if (rec_ch[i] !== ((i % 2) ? 3 : 0) || rec_d[i] !== msg((i % 2) ? 3 : 0, i / 2)) begin
        errors++; $display("FAIL rr_grant[%0d] got ch=%0d d=%h exp ch=%0d d=%h",
                           i, rec_ch[i], rec_d[i], (i % 2) ? 3 : 0, msg((i % 2) ? 3 : 0, i / 2));
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    in_valid = 6'b001110;
    for (int c = 1; c < 4; c++) in_data[c*W +: W] = msg(c, 0);
    tick();
    in_valid = '0;
    tick();
    checks++;
    if (is_processing !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL clr_pre got proc=%b v=%b exp 1 1", is_processing, out_valid);
    end
    clear = 1'b1;
    in_valid = 6'b000001;
    in_data[0*W +: W] = msg(0, 7);
    #1;
    checks++;
    if (is_taken !== 6'b0) begin errors++; $display("FAIL clr_taken got %b exp 000000", is_taken); end
    tick();
    clear = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || is_processing !== 1'b0 || is_taken !== 6'b000001) begin
      errors++; $display("FAIL clr_post got v=%b proc=%b taken=%b exp 0 0 000001", out_valid, is_processing, is_taken);
    end
    tick();
    in_valid = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || is_processing !== 1'b1) begin
      errors++; $display("FAIL clr_buf got v=%b proc=%b exp 0 1", out_valid, is_processing);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 3'd0 || out_data !== msg(0, 7)) begin
      errors++; $display("FAIL clr_out got v=%b ch=%0d d=%h exp 1 0 %h", out_valid, out_channel, out_data, msg(0, 7));
    end
`ifdef DIRECT_ARBITER_STATS_EN
    checks++;
    if (stat_accepted !== 16'd1) begin errors++; $display("FAIL clr_stats got acc=%0d exp 1", stat_accepted); end
`endif
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = '1;
    for (int c = 0; c < CC; c++) in_data[c*W +: W] = msg(c, 1);
    tick();
    in_valid = '0;
    tick();
    reset = 1'b1;
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    clear = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || is_processing !== 1'b0 || out_data !== '0 || out_channel !== 3'd0) begin
      errors++; $display("FAIL midrst got v=%b proc=%b d=%h ch=%0d exp all zero", out_valid, is_processing, out_data, out_channel);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got v=%b exp 0", out_valid); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_channels();
    test_full_backpressure();
    test_round_robin();
    test_clear();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
